fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, first PC fetched after reset.
REQ-002 Parameter DEPTH, default 2, fetch-queue entries; only value 2 is supported.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc_addr  output  64  fetch address driven to instruction memory; equals internal pc_q combinationally.
REQ-006 imem_instr  input  32  instruction word returned combinationally for pc_addr.
REQ-007 imem_exc_en / imem_exc_code / imem_exc_val  input  1/4/64  memory access fault, cause, faulting address.
REQ-008 redirect_en / redirect_pc  input  1/64  branch/trap redirect request and target.
REQ-009 id_valid  output  1  queue head valid toward decode.
REQ-010 id_ready  input  1  decode accepts head this cycle.
REQ-011 id_instr / id_pc  output  32/64  head instruction and its PC.
REQ-012 id_exc_en / id_exc_code / id_exc_val  output  1/4/64  head exception tag.

Function
REQ-013 Pop occurs in a cycle where id_valid=1 and id_ready=1; the head advances on that clock edge.
REQ-014 Push is permitted when state=RUN, redirect_en=0, and either count<2 or a pop occurs in the same cycle.
REQ-015 A push captures {imem_instr, pc_q, exception tag} into the tail and sets pc_q <= pc_q + 4, wrapping modulo 2^64.
REQ-016 Without a push, pc_q holds.
REQ-017 Simultaneous push and pop when full leaves count=2; when count=1, leaves count=1.
REQ-018 id_valid = (count!=0); all id_* outputs are driven from registers, giving 1-cycle latency from a pc_addr fetch to id_valid.
REQ-019 When the queue is empty: id_instr=32'h00000013, id_pc=0, id_exc_en=0, id_exc_code=0, id_exc_val=0.
REQ-020 The tag is taken from imem_exc_en/code/val (code 1, access fault) and is overridden by the misaligned tag per REQ-031.
REQ-021 An entry carrying an exception has id_instr=32'h00000013.
REQ-022 The FSM has two states: RUN and HOLD.
REQ-023 RUN->HOLD on a push whose entry has exc_en=1; in HOLD no pushes occur and pc_q holds.
REQ-024 HOLD->RUN only on redirect_en=1.
REQ-025 On redirect_en=1, all queue entries are discarded (count<=0) and any concurrent pop is ignored.
REQ-026 On redirect_en=1, pc_q<=redirect_pc, state<=RUN, and no push occurs in that cycle.
REQ-027 After a redirect in cycle N: pc_addr=redirect_pc in N+1, and id_valid=1 with id_pc=redirect_pc in N+2 (absent HOLD).
REQ-028 rst has priority over redirect_en, which has priority over push and pop.

Reset
REQ-029 On a clock edge with rst=1: pc_q<=RESET_PC, count<=0, state<=RUN; all id_* outputs take the empty values of REQ-019. This applies equally mid-operation: in-flight entries are lost and the first post-reset id_valid carries id_pc=RESET_PC.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN selects misaligned-PC checking.
REQ-031 With FETCH_MISALIGN_CHECK_EN defined: when pc_q[1:0]!=0, the pushed entry has exc_en=1, exc_code=0, exc_val=pc_q, instr=NOP, taking precedence over the imem exception; the FSM enters HOLD.
REQ-032 Without FETCH_MISALIGN_CHECK_EN: pc_q[1:0] is ignored and the fetch proceeds normally with the imem result.

Verification
REQ-033 RESET_PC=0, id_ready=1, rst released at cycle 0 -> id_valid=1 from cycle 1 with id_pc 0,4,8,... one per cycle, id_instr matching memory.
REQ-034 id_ready=0 for 5 cycles after reset -> count saturates at 2 holding pcs 0,4, pc_addr holds 8; id_ready=1 -> id_pc 0,4,8 consecutively, no loss or duplicate.
REQ-035 Queue full, redirect_en=1 with redirect_pc=0x100 and id_ready=1 -> next cycle id_valid=0, pc_addr=0x100; following cycle id_pc=0x100.
REQ-036 imem_exc_en=1, code 1, at pc 0x2000 -> entry id_exc_en=1, code 1, val 0x2000, instr 0x13; no further id_valid until redirect to 0x40, then id_pc=0x40.
REQ-037 Macro defined, redirect to 0x102 -> entry exc code 0, val 0x102, HOLD; macro undefined -> normal entry id_pc=0x102, next 0x106.
REQ-038 rst=1 asserted for one cycle with 2 entries queued -> id_valid=0 next cycle, then id_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with a two-entry queue toward decode.
//   Parameters : RESET_PC (first PC after reset), DEPTH (queue entries, only 2 supported)
//   clk, rst                          : clock, synchronous active-high reset
//   pc_addr                           : fetch address to instruction memory (= pc_q)
//   imem_instr, imem_exc_*            : combinational memory reply and access-fault tag
//   redirect_en, redirect_pc          : flush the queue and restart fetch at redirect_pc
//   id_valid, id_ready                : head handshake toward decode
//   id_instr, id_pc, id_exc_*         : head entry (NOP and zeros when the queue is empty)
//   Macro FETCH_MISALIGN_CHECK_EN     : tag fetches from pc_q[1:0]!=0 as misaligned (code 0)
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] pc_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    output logic        id_exc_en,
    output logic [3:0]  id_exc_code,
    output logic [63:0] id_exc_val
);
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [1:0]  FULL = 2'(DEPTH);

    typedef enum logic {RUN, HOLD} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } entry_t;

    localparam entry_t EMPTY = {NOP, 64'd0, 1'b0, 4'd0, 64'd0};

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d, kept;
    entry_t      head_q, head_d, tail_q, tail_d, new_e, head;
    logic        pop, push;

    always_ff @(posedge clk) begin
        state_q <= rst ? RUN : state_d;
    end

    always_comb begin
        state_d = redirect_en ? RUN : (push && new_e.exc_en) ? HOLD : state_q;
    end

    always_comb begin
        pop  = (count_q != 2'd0) && id_ready;
        push = (state_q == RUN) && !redirect_en && (count_q != FULL || pop);
    end

    // A faulting fetch carries a NOP so decode never sees the bogus word.
    always_comb begin
        new_e = imem_exc_en ? {NOP, pc_q, 1'b1, imem_exc_code, imem_exc_val}
                            : {imem_instr, pc_q, 1'b0, 4'd0, 64'd0};
`ifdef FETCH_MISALIGN_CHECK_EN
        if (pc_q[1:0] != 2'b00) new_e = {NOP, pc_q, 1'b1, 4'd0, pc_q};
`endif
    end

    // Head/tail shift queue: a pop moves the tail into the head, then a push
    // lands in the first slot left free.
    always_comb begin
        kept    = count_q - {1'b0, pop};
        head_d  = pop ? tail_q : head_q;
        tail_d  = tail_q;
        if (push && kept == 2'd0) head_d = new_e;
        if (push && kept != 2'd0) tail_d = new_e;
        count_d = redirect_en ? 2'd0 : kept + {1'b0, push};
        pc_d    = redirect_en ? redirect_pc : push ? pc_q + 64'd4 : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            head_q  <= EMPTY;
            tail_q  <= EMPTY;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign pc_addr     = pc_q;
    assign id_valid    = count_q != 2'd0;
    assign head        = id_valid ? head_q : EMPTY;
    assign id_instr    = head.instr;
    assign id_pc       = head.pc;
    assign id_exc_en   = head.exc_en;
    assign id_exc_code = head.exc_code;
    assign id_exc_val  = head.exc_val;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based model.
module tb_fetch_unit;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        id_exc_en;
    logic [3:0]  id_exc_code;
    logic [63:0] id_exc_val;

    logic        fault_en = 1'b0;
    logic [63:0] fault_addr = 64'h0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        exc;
        logic [3:0]  code;
        logic [63:0] val;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc = RESET_PC;
    bit          m_hold = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr),
        .imem_instr(imem_instr), .imem_exc_en(imem_exc_en),
        .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_exc_en(id_exc_en), .id_exc_code(id_exc_code), .id_exc_val(id_exc_val)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    always_comb begin
        imem_instr    = mem(pc_addr);
        imem_exc_en   = fault_en && pc_addr == fault_addr;
        imem_exc_code = 4'd1;
        imem_exc_val  = pc_addr;
    end

    // Reference: a FIFO of at most two fetched entries, a PC and a stall flag.
    task automatic tick();
        ent_t e;
        bit   pop;
        pop = q.size() != 0 && id_ready;
        if (rst) begin
            q.delete(); m_pc = RESET_PC; m_hold = 0;
        end else if (redirect_en) begin
            q.delete(); m_pc = redirect_pc; m_hold = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (!m_hold && q.size() < 2) begin
                e = '{instr: mem(m_pc), pc: m_pc, exc: 1'b0, code: 4'd0, val: 64'd0};
                if (fault_en && m_pc == fault_addr) e = '{instr: NOP, pc: m_pc, exc: 1'b1, code: 4'd1, val: m_pc};
`ifdef FETCH_MISALIGN_CHECK_EN
                if (m_pc % 4 != 0) e = '{instr: NOP, pc: m_pc, exc: 1'b1, code: 4'd0, val: m_pc};
`endif
                q.push_back(e);
                m_pc = m_pc + 64'd4;
                if (e.exc) m_hold = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [229:0] exp_vec();
        if (q.size() == 0) return {1'b0, NOP, 64'd0, 1'b0, 4'd0, 64'd0, m_pc};
        return {1'b1, q[0].instr, q[0].pc, q[0].exc, q[0].code, q[0].val, m_pc};
    endfunction

    function automatic logic [229:0] dut_vec();
        return {id_valid, id_instr, id_pc, id_exc_en, id_exc_code, id_exc_val, pc_addr};
    endfunction

    task automatic test_reset();
        rst = 1; redirect_en = 1; redirect_pc = 64'h500; id_ready = 1;
        tick();
        tick();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL reset got=%h exp=%h", dut_vec(), exp_vec()); errors++;
        end
        checks++;
        if (id_valid !== 1'b0 || id_instr !== NOP || pc_addr !== RESET_PC) begin
            $display("FAIL reset_const valid=%b instr=%h pc_addr=%h exp 0/%h/%h", id_valid, id_instr, pc_addr, NOP, RESET_PC); errors++;
        end
        redirect_en = 0;
    endtask

    task automatic test_stream();
        rst = 0; id_ready = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || id_pc !== 64'(4 * i)) begin
                $display("FAIL stream cyc=%0d got=%h exp=%h id_pc=%h", i, dut_vec(), exp_vec(), id_pc); errors++;
            end
        end
    endtask

    task automatic test_backpressure();
        rst = 1; tick(); rst = 0; id_ready = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) id_ready = 1;
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); errors++;
            end
            if (i == 4) begin
                checks++;
                if (pc_addr !== 64'h8 || id_pc !== 64'h0) begin
                    $display("FAIL backpressure_full pc_addr=%h id_pc=%h exp 8/0", pc_addr, id_pc); errors++;
                end
            end
        end
    endtask

    task automatic test_redirect();
        id_ready = 0;
        tick(); tick(); tick();
        id_ready = 1; redirect_en = 1; redirect_pc = 64'h100;
        tick();
        redirect_en = 0;
        checks++;
        if (dut_vec() !== exp_vec() || id_valid !== 1'b0 || pc_addr !== 64'h100) begin
            $display("FAIL redirect_flush got=%h exp=%h", dut_vec(), exp_vec()); errors++;
        end
        tick();
        checks++;
        if (dut_vec() !== exp_vec() || id_pc !== 64'h100 || id_valid !== 1'b1) begin
            $display("FAIL redirect_target got=%h exp=%h", dut_vec(), exp_vec()); errors++;
        end
    endtask

    task automatic test_fault();
        fault_en = 1; fault_addr = 64'h2000; id_ready = 0;
        redirect_en = 1; redirect_pc = 64'h2000;
        tick();
        redirect_en = 0;
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_exc_en !== 1'b1 || id_exc_code !== 4'd1 || id_exc_val !== 64'h2000 || id_instr !== NOP) begin
            $display("FAIL fault_entry got=%h", dut_vec()); errors++;
        end
        id_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec() || id_valid !== 1'b0) begin
                $display("FAIL fault_hold cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); errors++;
            end
        end
        redirect_en = 1; redirect_pc = 64'h40;
        tick();
        redirect_en = 0;
        tick();
        checks++;
        if (dut_vec() !== exp_vec() || id_pc !== 64'h40) begin
            $display("FAIL fault_recover got=%h exp=%h", dut_vec(), exp_vec()); errors++;
        end
        fault_en = 0;
    endtask

    task automatic test_misalign();
        id_ready = 0; redirect_en = 1; redirect_pc = 64'h102;
        tick();
        redirect_en = 0;
        tick();
        checks++;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (id_exc_en !== 1'b1 || id_exc_code !== 4'd0 || id_exc_val !== 64'h102 || id_instr !== NOP) begin
            $display("FAIL misalign_entry got=%h", dut_vec()); errors++;
        end
`else
        if (id_exc_en !== 1'b0 || id_pc !== 64'h102 || id_instr !== mem(64'h102)) begin
            $display("FAIL misalign_entry got=%h", dut_vec()); errors++;
        end
`endif
        id_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL misalign_run cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); errors++;
            end
        end
    endtask

    task automatic test_mid_reset();
        redirect_en = 1; redirect_pc = 64'h800; id_ready = 0;
        tick();
        redirect_en = 0;
        tick(); tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (dut_vec() !== exp_vec() || id_valid !== 1'b0) begin
            $display("FAIL midreset_flush got=%h exp=%h", dut_vec(), exp_vec()); errors++;
        end
        tick();
        checks++;
        if (dut_vec() !== exp_vec() || id_valid !== 1'b1 || id_pc !== RESET_PC) begin
            $display("FAIL midreset_first got=%h exp=%h", dut_vec(), exp_vec()); errors++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            id_ready    = $urandom_range(0, 3) != 0;
            rst         = $urandom_range(0, 79) == 0;
            redirect_en = $urandom_range(0, 11) == 0;
            case ($urandom_range(0, 4))
                0: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
                1: redirect_pc = {32'h0, $urandom} & ~64'h1 | 64'h2;
                default: redirect_pc = {$urandom, $urandom} & ~64'h3;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                fault_en   = $urandom_range(0, 1) == 1;
                fault_addr = m_pc + 64'(4 * $urandom_range(0, 3));
            end
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec()); errors++;
            end
        end
        rst = 0; redirect_en = 0; fault_en = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_misalign();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
